// File: rtl/regfile_piped.sv
// Integer physical register file with a ready-bit scoreboard.
// Reads are registered (one-cycle latency) and see same-cycle writeback data.
// The scoreboard is cleared by rename marks, set by writebacks, and fully
// restored by a flush.
module regfile_piped #(
  parameter int READPORT_NUM = 10,
  parameter int WBPORT_NUM   = 6,
  parameter int MARK_NUM     = 4,
  parameter int CHECK_NUM    = 8,
  parameter int SIZE         = 80,
  parameter int XLEN         = 64,
  parameter int HAS_ZERO     = 1,
  localparam int IDX_W       = $clog2(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic [MARK_NUM-1:0]     i_mark_en,
  input  logic [IDX_W-1:0]        i_mark_idx   [MARK_NUM],
  input  logic [IDX_W-1:0]        i_check_idx  [CHECK_NUM],
  output logic [CHECK_NUM-1:0]    o_check_rdy,
  input  logic [READPORT_NUM-1:0] i_read_en,
  input  logic [IDX_W-1:0]        i_read_idx   [READPORT_NUM],
  output logic [READPORT_NUM-1:0] o_read_vld,
  output logic [READPORT_NUM-1:0] o_read_rdy,
  output logic [XLEN-1:0]         o_read_data  [READPORT_NUM],
  input  logic [WBPORT_NUM-1:0]   i_write_en,
  input  logic [IDX_W-1:0]        i_write_idx  [WBPORT_NUM],
  input  logic [XLEN-1:0]         i_write_data [WBPORT_NUM],
  output logic                    o_write_conflict
);

  logic [XLEN-1:0]         mem [SIZE];
  logic [SIZE-1:0]         rdy_bit;
  logic [WBPORT_NUM-1:0]   wr_ok;
  logic [MARK_NUM-1:0]     mark_ok;
  logic                    wr_conflict;
  logic [XLEN-1:0]         rd_data_nx [READPORT_NUM];
  logic [READPORT_NUM-1:0] rd_rdy_nx;

  logic [READPORT_NUM-1:0] vld_p1;
  logic [READPORT_NUM-1:0] rd_rdy_p1;
  logic [XLEN-1:0]         rd_data_p1 [READPORT_NUM];
  logic                    conflict_p1;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < SIZE;
  endfunction

  function automatic logic idx_is_zero(input logic [IDX_W-1:0] idx);
    return (HAS_ZERO != 0) && (idx == '0);
  endfunction

  function automatic logic idx_writable(input logic [IDX_W-1:0] idx);
    return idx_in_range(idx) && !idx_is_zero(idx);
  endfunction

  // Qualify write and mark ports: hardwired zero and out-of-range targets are dropped
  always_comb begin
    for (int w = 0; w < WBPORT_NUM; w++)
      wr_ok[w] = i_write_en[w] && idx_writable(i_write_idx[w]);
    for (int m = 0; m < MARK_NUM; m++)
      mark_ok[m] = i_mark_en[m] && idx_writable(i_mark_idx[m]);
  end

  // Detect two enabled writeback ports aiming at the same index
  always_comb begin
    wr_conflict = 1'b0;
    for (int a = 0; a < WBPORT_NUM; a++)
      for (int b = a + 1; b < WBPORT_NUM; b++)
        if (i_write_en[a] && i_write_en[b] && (i_write_idx[a] == i_write_idx[b]))
          wr_conflict = 1'b1;
  end

  // Read lookup with writeback bypass; the highest-numbered matching port wins
  always_comb begin
    for (int r = 0; r < READPORT_NUM; r++) begin
      rd_data_nx[r] = '0;
      rd_rdy_nx[r]  = 1'b0;
      if (idx_is_zero(i_read_idx[r])) begin
        rd_rdy_nx[r] = 1'b1;
      end else if (idx_in_range(i_read_idx[r])) begin
        rd_data_nx[r] = mem[i_read_idx[r]];
        rd_rdy_nx[r]  = rdy_bit[i_read_idx[r]];
        for (int w = 0; w < WBPORT_NUM; w++)
          if (wr_ok[w] && (i_write_idx[w] == i_read_idx[r])) begin
            rd_data_nx[r] = i_write_data[w];
            rd_rdy_nx[r]  = 1'b1;
          end
      end
    end
  end

  // Dispatch ready check: scoreboard plus same-cycle writebacks (marks/flush land next cycle)
  always_comb begin
    for (int c = 0; c < CHECK_NUM; c++) begin
      o_check_rdy[c] = 1'b0;
      if (idx_is_zero(i_check_idx[c])) begin
        o_check_rdy[c] = 1'b1;
      end else if (idx_in_range(i_check_idx[c])) begin
        o_check_rdy[c] = rdy_bit[i_check_idx[c]];
        for (int w = 0; w < WBPORT_NUM; w++)
          if (wr_ok[w] && (i_write_idx[w] == i_check_idx[c]))
            o_check_rdy[c] = 1'b1;
      end
    end
  end

  // Storage write; later loop iterations override earlier ones so the highest port wins
  always_ff @(posedge clk) begin
    for (int w = 0; w < WBPORT_NUM; w++)
      if (wr_ok[w])
        mem[i_write_idx[w]] <= i_write_data[w];
  end

  // Scoreboard: flush > mark > write > hold (marks are applied after writes so they win)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_bit <= '1;
    end else if (i_flush) begin
      rdy_bit <= '1;
    end else begin
      for (int w = 0; w < WBPORT_NUM; w++)
        if (wr_ok[w])
          rdy_bit[i_write_idx[w]] <= 1'b1;
      for (int m = 0; m < MARK_NUM; m++)
        if (mark_ok[m])
          rdy_bit[i_mark_idx[m]] <= 1'b0;
    end
  end

  // ---- stage p0 -> p1: registered read results and conflict flag ----
  // Data and ready hold when a port is idle; only valid tracks the request every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= '0;
      rd_rdy_p1   <= '0;
      conflict_p1 <= 1'b0;
      for (int r = 0; r < READPORT_NUM; r++)
        rd_data_p1[r] <= '0;
    end else begin
      vld_p1      <= i_read_en;
      conflict_p1 <= wr_conflict;
      for (int r = 0; r < READPORT_NUM; r++)
        if (i_read_en[r]) begin
          rd_data_p1[r] <= rd_data_nx[r];
          rd_rdy_p1[r]  <= rd_rdy_nx[r];
        end
    end
  end

  assign o_read_vld       = vld_p1;
  assign o_read_rdy       = rd_rdy_p1;
  assign o_read_data      = rd_data_p1;
  assign o_write_conflict = conflict_p1;

  // Simulation checks: out-of-range writeback, and mark/write collisions on a live register
  always @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < WBPORT_NUM; w++) begin
        assert (!(i_write_en[w] && !idx_in_range(i_write_idx[w])))
          else $error("regfile_piped: write port %0d targets index %0d beyond SIZE", w, i_write_idx[w]);
        for (int m = 0; m < MARK_NUM; m++)
          assert (!(i_write_en[w] && i_mark_en[m] && (i_write_idx[w] == i_mark_idx[m]) &&
                    (i_write_idx[w] != '0)))
            else $warning("regfile_piped: mark %0d and write %0d hit index %0d together", m, w, i_write_idx[w]);
      end
    end
  end

endmodule

// File: tb/tb_regfile_piped.sv
// Testbench for regfile_piped: directed scenarios plus randomized traffic
// checked against a behavioural register-file/scoreboard model.
module tb_regfile_piped;
  localparam int RP = 10, WB = 6, MK = 4, CK = 8, SIZE = 80, XLEN = 64, IW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_flush;
  logic [MK-1:0]   i_mark_en;
  logic [IW-1:0]   i_mark_idx [MK];
  logic [IW-1:0]   i_check_idx [CK];
  logic [CK-1:0]   o_check_rdy;
  logic [RP-1:0]   i_read_en, o_read_vld, o_read_rdy;
  logic [IW-1:0]   i_read_idx [RP];
  logic [XLEN-1:0] o_read_data [RP];
  logic [WB-1:0]   i_write_en;
  logic [IW-1:0]   i_write_idx [WB];
  logic [XLEN-1:0] i_write_data [WB];
  logic            o_write_conflict;

  regfile_piped #(
    .READPORT_NUM(RP), .WBPORT_NUM(WB), .MARK_NUM(MK), .CHECK_NUM(CK),
    .SIZE(SIZE), .XLEN(XLEN), .HAS_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_mark_en(i_mark_en), .i_mark_idx(i_mark_idx),
    .i_check_idx(i_check_idx), .o_check_rdy(o_check_rdy),
    .i_read_en(i_read_en), .i_read_idx(i_read_idx),
    .o_read_vld(o_read_vld), .o_read_rdy(o_read_rdy), .o_read_data(o_read_data),
    .i_write_en(i_write_en), .i_write_idx(i_write_idx), .i_write_data(i_write_data),
    .o_write_conflict(o_write_conflict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] m_mem [SIZE];
  bit              m_rdy [SIZE];
  bit              m_known [SIZE];
  // Expected registered outputs and combinational checks
  logic [XLEN-1:0] e_data [RP];
  bit              e_rdy [RP];
  bit              e_dk [RP];
  bit              e_vld [RP];
  bit              e_chk [CK];
  bit              e_conf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_flush    = 1'b0;
    i_mark_en  = '0;
    i_read_en  = '0;
    i_write_en = '0;
    for (int i = 0; i < MK; i++) i_mark_idx[i] = '0;
    for (int i = 0; i < CK; i++) i_check_idx[i] = '0;
    for (int i = 0; i < RP; i++) i_read_idx[i] = '0;
    for (int i = 0; i < WB; i++) begin
      i_write_idx[i]  = '0;
      i_write_data[i] = '0;
    end
  endtask

  // What a reader of idx sees this cycle: register contents overlaid by this cycle's writebacks
  function automatic void peek(input logic [IW-1:0] idx, output logic [XLEN-1:0] d,
                               output bit r, output bit k);
    int n;
    n = int'(idx);
    d = '0; r = 1'b0; k = 1'b1;
    if (n == 0) begin
      r = 1'b1;
    end else if (n < SIZE) begin
      d = m_mem[n]; r = m_rdy[n]; k = m_known[n];
      for (int w = 0; w < WB; w++)
        if (i_write_en[w] && int'(i_write_idx[w]) == n) begin
          d = i_write_data[w]; r = 1'b1; k = 1'b1;
        end
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < SIZE; i++) m_rdy[i] = 1'b1;
    for (int r = 0; r < RP; r++) begin
      e_data[r] = '0; e_rdy[r] = 1'b0; e_dk[r] = 1'b1; e_vld[r] = 1'b0;
    end
    e_conf = 1'b0;
  endfunction

  function automatic void model_check();
    logic [XLEN-1:0] d;
    bit r, k;
    for (int c = 0; c < CK; c++) begin
      peek(i_check_idx[c], d, r, k);
      e_chk[c] = r;
    end
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  function automatic void model_step();
    bit marked [SIZE];
    bit written [SIZE];
    logic [XLEN-1:0] d;
    bit r, k;
    for (int p = 0; p < RP; p++) begin
      e_vld[p] = i_read_en[p];
      if (i_read_en[p]) begin
        peek(i_read_idx[p], d, r, k);
        e_data[p] = d; e_rdy[p] = r; e_dk[p] = k;
      end
    end
    e_conf = 1'b0;
    for (int a = 0; a < WB; a++)
      for (int b = 0; b < WB; b++)
        if (a != b && i_write_en[a] && i_write_en[b] && i_write_idx[a] == i_write_idx[b])
          e_conf = 1'b1;
    for (int i = 0; i < SIZE; i++) begin marked[i] = 1'b0; written[i] = 1'b0; end
    for (int w = 0; w < WB; w++)
      if (i_write_en[w] && int'(i_write_idx[w]) < SIZE && i_write_idx[w] != 0) begin
        m_mem[i_write_idx[w]]   = i_write_data[w];
        m_known[i_write_idx[w]] = 1'b1;
        written[i_write_idx[w]] = 1'b1;
      end
    for (int m = 0; m < MK; m++)
      if (i_mark_en[m] && int'(i_mark_idx[m]) < SIZE && i_mark_idx[m] != 0)
        marked[i_mark_idx[m]] = 1'b1;
    for (int i = 0; i < SIZE; i++)
      if (i_flush) m_rdy[i] = 1'b1;
      else if (marked[i]) m_rdy[i] = 1'b0;
      else if (written[i]) m_rdy[i] = 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < SIZE; i++) m_known[i] = 1'b0;
    model_reset();
    #2;
    checks++;
    if (o_read_vld !== '0 || o_read_rdy !== '0) begin
      errors++; $display("FAIL reset_vld_rdy: vld=%h rdy=%h, want 0", o_read_vld, o_read_rdy);
    end
    for (int r = 0; r < RP; r++) begin
      checks++;
      if (o_read_data[r] !== '0) begin
        errors++; $display("FAIL reset_data[%0d]: got %h, want 0", r, o_read_data[r]);
      end
    end
    checks++;
    if (o_write_conflict !== 1'b0) begin
      errors++; $display("FAIL reset_conflict: got %b, want 0", o_write_conflict);
    end
    tick(); tick();
    rst = 1'b0;
    i_check_idx[0] = 7'd5;
    i_read_en[0] = 1'b1; i_read_idx[0] = 7'd5;
    #1;
    checks++;
    if (o_check_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL reset_check5: got %b, want 1", o_check_rdy[0]);
    end
    model_step();
    tick();
    checks++;
    if (o_read_vld[0] !== 1'b1 || o_read_rdy[0] !== 1'b1 || o_read_vld[1] !== 1'b0) begin
      errors++; $display("FAIL reset_read5: vld=%b rdy=%b vld1=%b, want 1 1 0",
                         o_read_vld[0], o_read_rdy[0], o_read_vld[1]);
    end
    idle();
  endtask

  // Give every register a known value so later data comparisons are meaningful
  task automatic test_init_storage();
    for (int base = 1; base < SIZE; base += WB) begin
      idle();
      for (int w = 0; w < WB; w++)
        if (base + w < SIZE) begin
          i_write_en[w] = 1'b1;
          i_write_idx[w] = IW'(base + w);
          i_write_data[w] = {$urandom, $urandom};
        end
      #1;
      model_step();
      tick();
      checks++;
      if (o_write_conflict !== 1'b0) begin
        errors++; $display("FAIL init_conflict: got %b, want 0", o_write_conflict);
      end
    end
    idle();
  endtask

  task automatic test_mark_then_write();
    i_mark_en[0] = 1'b1; i_mark_idx[0] = 7'd7;
    #1; model_step(); tick(); idle();
    i_check_idx[0] = 7'd7;
    #1;
    checks++;
    if (o_check_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL mark_check7: got %b, want 0", o_check_rdy[0]);
    end
    model_step(); tick(); idle();
    #1; model_step(); tick();
    i_write_en[2] = 1'b1; i_write_idx[2] = 7'd7; i_write_data[2] = 64'hDEAD;
    i_check_idx[0] = 7'd7;
    i_read_en[3] = 1'b1; i_read_idx[3] = 7'd7;
    #1;
    checks++;
    if (o_check_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL wb_check7: got %b, want 1", o_check_rdy[0]);
    end
    model_step(); tick();
    checks++;
    if (o_read_vld[3] !== 1'b1 || o_read_rdy[3] !== 1'b1 || o_read_data[3] !== 64'hDEAD) begin
      errors++; $display("FAIL wb_fwd7: vld=%b rdy=%b data=%h, want 1 1 dead",
                         o_read_vld[3], o_read_rdy[3], o_read_data[3]);
    end
    idle();
  endtask

  task automatic test_write_conflict();
    i_write_en[1] = 1'b1; i_write_idx[1] = 7'd12; i_write_data[1] = 64'h11;
    i_write_en[4] = 1'b1; i_write_idx[4] = 7'd12; i_write_data[4] = 64'h44;
    i_read_en[0] = 1'b1; i_read_idx[0] = 7'd12;
    #1; model_step(); tick(); idle();
    checks++;
    if (o_read_data[0] !== 64'h44 || o_write_conflict !== 1'b1) begin
      errors++; $display("FAIL conflict_fwd: data=%h conf=%b, want 44 1", o_read_data[0], o_write_conflict);
    end
    i_read_en[5] = 1'b1; i_read_idx[5] = 7'd12;
    #1; model_step(); tick(); idle();
    checks++;
    if (o_read_data[5] !== 64'h44 || o_write_conflict !== 1'b0 || o_read_vld[0] !== 1'b0) begin
      errors++; $display("FAIL conflict_store: data=%h conf=%b vld0=%b, want 44 0 0",
                         o_read_data[5], o_write_conflict, o_read_vld[0]);
    end
    checks++;
    if (o_read_data[0] !== 64'h44) begin
      errors++; $display("FAIL idle_hold: data=%h, want 44", o_read_data[0]);
    end
  endtask

  task automatic test_mark_beats_write();
    i_mark_en[2] = 1'b1; i_mark_idx[2] = 7'd20;
    i_write_en[0] = 1'b1; i_write_idx[0] = 7'd20; i_write_data[0] = 64'h0123_4567_89AB_CDEF;
    #1; model_step(); tick(); idle();
    i_check_idx[3] = 7'd20;
    i_read_en[1] = 1'b1; i_read_idx[1] = 7'd20;
    #1;
    checks++;
    if (o_check_rdy[3] !== 1'b0) begin
      errors++; $display("FAIL markwin_check: got %b, want 0", o_check_rdy[3]);
    end
    model_step(); tick(); idle();
    checks++;
    if (o_read_data[1] !== 64'h0123_4567_89AB_CDEF || o_read_rdy[1] !== 1'b0) begin
      errors++; $display("FAIL markwin_data: data=%h rdy=%b, want 0123456789abcdef 0",
                         o_read_data[1], o_read_rdy[1]);
    end
  endtask

  task automatic test_flush();
    i_mark_en[0] = 1'b1; i_mark_idx[0] = 7'd30;
    i_mark_en[1] = 1'b1; i_mark_idx[1] = 7'd31;
    #1; model_step(); tick(); idle();
    i_flush = 1'b1;
    i_mark_en[3] = 1'b1; i_mark_idx[3] = 7'd33;
    i_check_idx[0] = 7'd30;
    #1;
    checks++;
    if (o_check_rdy[0] !== 1'b0) begin
      errors++; $display("FAIL flush_same_cycle: got %b, want 0", o_check_rdy[0]);
    end
    model_step(); tick(); idle();
    i_check_idx[0] = 7'd30; i_check_idx[1] = 7'd31; i_check_idx[2] = 7'd33;
    #1;
    checks++;
    if (o_check_rdy[2:0] !== 3'b111) begin
      errors++; $display("FAIL flush_restore: got %b, want 111", o_check_rdy[2:0]);
    end
    model_step(); tick(); idle();
  endtask

  task automatic test_zero_and_range();
    i_write_en[0] = 1'b1; i_write_idx[0] = 7'd0; i_write_data[0] = 64'hFF;
    i_mark_en[0] = 1'b1; i_mark_idx[0] = 7'd0;
    i_read_en[0] = 1'b1; i_read_idx[0] = 7'd0;
    i_read_en[1] = 1'b1; i_read_idx[1] = 7'd80;
    i_check_idx[0] = 7'd0; i_check_idx[1] = 7'd80;
    #1;
    checks++;
    if (o_check_rdy[1:0] !== 2'b01) begin
      errors++; $display("FAIL zero_range_check: got %b, want 01", o_check_rdy[1:0]);
    end
    model_step(); tick(); idle();
    checks++;
    if (o_read_data[0] !== '0 || o_read_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL zero_read: data=%h rdy=%b, want 0 1", o_read_data[0], o_read_rdy[0]);
    end
    checks++;
    if (o_read_data[1] !== '0 || o_read_rdy[1] !== 1'b0) begin
      errors++; $display("FAIL range_read: data=%h rdy=%b, want 0 0", o_read_data[1], o_read_rdy[1]);
    end
  endtask

  task automatic test_reset_midop();
    i_mark_en[0] = 1'b1; i_mark_idx[0] = 7'd40;
    i_read_en = '1;
    for (int r = 0; r < RP; r++) i_read_idx[r] = IW'($urandom_range(1, SIZE - 1));
    #1; model_step(); tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_read_vld !== '0 || o_read_data[0] !== '0) begin
      errors++; $display("FAIL midop_async: vld=%h data=%h, want 0 0", o_read_vld, o_read_data[0]);
    end
    tick();
    rst = 1'b0;
    model_reset();
    idle();
    i_check_idx[0] = 7'd40;
    #1;
    checks++;
    if (o_read_vld !== '0 || o_check_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL midop_after: vld=%h chk40=%b, want 0 1", o_read_vld, o_check_rdy[0]);
    end
    model_step(); tick(); idle();
  endtask

  task automatic test_random(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      idle();
      i_flush = ($urandom_range(0, 15) == 0);
      for (int w = 0; w < WB; w++) begin
        i_write_en[w] = ($urandom_range(0, 1) == 1);
        i_write_idx[w] = (w > 0 && $urandom_range(0, 7) == 0) ? i_write_idx[w-1]
                                                                : IW'($urandom_range(0, SIZE - 1));
        i_write_data[w] = {$urandom, $urandom};
      end
      for (int m = 0; m < MK; m++) begin
        i_mark_en[m] = ($urandom_range(0, 2) == 0);
        i_mark_idx[m] = IW'($urandom_range(0, 99));
        for (int w = 0; w < WB; w++)
          if (i_write_en[w] && i_write_idx[w] == i_mark_idx[m]) i_mark_idx[m] = '0;
      end
      for (int r = 0; r < RP; r++) begin
        i_read_en[r] = ($urandom_range(0, 3) != 0);
        i_read_idx[r] = (r < WB && $urandom_range(0, 3) == 0) ? i_write_idx[r]
                                                              : IW'($urandom_range(0, 90));
      end
      for (int c = 0; c < CK; c++)
        i_check_idx[c] = (c < WB && $urandom_range(0, 3) == 0) ? i_write_idx[c]
                                                               : IW'($urandom_range(0, 90));
      #1;
      model_check();
      for (int c = 0; c < CK; c++) begin
        checks++;
        if (o_check_rdy[c] !== e_chk[c]) begin
          errors++; $display("FAIL rand_check[%0d] cyc %0d idx %0d: got %b, want %b",
                             c, n, i_check_idx[c], o_check_rdy[c], e_chk[c]);
        end
      end
      model_step();
      tick();
      for (int r = 0; r < RP; r++) begin
        checks++;
        if (o_read_vld[r] !== e_vld[r] || o_read_rdy[r] !== e_rdy[r] ||
            (e_dk[r] && o_read_data[r] !== e_data[r])) begin
          errors++; $display("FAIL rand_read[%0d] cyc %0d: vld=%b rdy=%b data=%h, want %b %b %h",
                             r, n, o_read_vld[r], o_read_rdy[r], o_read_data[r],
                             e_vld[r], e_rdy[r], e_data[r]);
        end
      end
      checks++;
      if (o_write_conflict !== e_conf) begin
        errors++; $display("FAIL rand_conflict cyc %0d: got %b, want %b", n, o_write_conflict, e_conf);
      end
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init_storage();
    test_mark_then_write();
    test_write_conflict();
    test_mark_beats_write();
    test_flush();
    test_zero_and_range();
    test_reset_midop();
    test_random(400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_piped.md
Name: regfile_piped

Overview:
- Next-generation integer physical register file with a ready-bit scoreboard.
- Read ports are registered with one-cycle latency; same-cycle writeback data is forwarded into the read pipeline.
- Adds a flush-driven scoreboard recovery and defined priority for write/mark collisions.
- Sits between rename/dispatch (ready marks and checks) and the issue/execute read stage, with writeback from the execution units.

Parameters:
- READPORT_NUM, 10, number of registered read ports
- WBPORT_NUM, 6, number of writeback ports
- MARK_NUM, 4, number of rename not-ready mark ports
- CHECK_NUM, 8, number of dispatch ready-check ports
- SIZE, 80, number of physical registers
- XLEN, 64, data width
- HAS_ZERO, 1, nonzero: index 0 is hardwired zero and always ready

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- i_flush  input  1  pipeline flush; restore all ready bits
- i_mark_en  input  MARK_NUM  per-port not-ready mark enable
- i_mark_idx  input  MARK_NUM x clog2(SIZE)  register to mark not ready
- i_check_idx  input  CHECK_NUM x clog2(SIZE)  dispatch ready query
- o_check_rdy  output  CHECK_NUM  combinational ready answer
- i_read_en  input  READPORT_NUM  read request valid
- i_read_idx  input  READPORT_NUM x clog2(SIZE)  read index
- o_read_vld  output  READPORT_NUM  read result valid, 1 cycle after request
- o_read_rdy  output  READPORT_NUM  ready bit of the read register
- o_read_data  output  READPORT_NUM x XLEN  read data
- i_write_en  input  WBPORT_NUM  writeback enable
- i_write_idx  input  WBPORT_NUM x clog2(SIZE)  writeback index
- i_write_data  input  WBPORT_NUM x XLEN  writeback data
- o_write_conflict  output  1  registered flag: two enabled writes hit the same index last cycle

Behaviour:
- Reset is asynchronous on rst rising and held while high:
  - rdy_bit is all 1 (initial architectural mappings are ready).
  - o_read_vld, o_read_rdy, o_read_data and o_write_conflict are 0.
  - Storage array is not reset.
- Data write: at posedge, each enabled port stores its data. If several ports target the same index, the highest port number wins, and o_write_conflict=1 the following cycle.
- rdy_bit next-state, in priority order (highest first):
  - i_flush: all bits become 1. Marks and writes in the same cycle do not affect rdy; data writes still occur.
  - Mark: an enabled mark on index k clears bit k. A mark beats a same-cycle write to k, because the new allocation is younger.
  - Write: an enabled write to k sets bit k.
  - Otherwise the bit holds.
- HAS_ZERO≠0, index 0:
  - Writes and marks to index 0 are ignored.
  - Reads of index 0 return data 0 with rdy 1.
  - Checks of index 0 return 1.
- Index ≥ SIZE: writes and marks are ignored; reads return data 0, rdy 0; checks return 0.
- Read pipeline, request at cycle T, result at T+1:
  - o_read_vld = i_read_en at T.
  - o_read_data = data from the highest-numbered port writing the same index at T if any, otherwise storage at T.
  - o_read_rdy = rdy_bit at T OR any write to that index at T. Marks at T are not reflected.
  - When i_read_en=0, o_read_vld=0 and data/rdy hold their previous values.
- Dispatch check (combinational): o_check_rdy = rdy_bit OR same-cycle write to the index. Same-cycle marks and flush are not visible until the next cycle.
- Reset asserted mid-operation discards in-flight read results; the first cycle after reset has o_read_vld=0.
- Assertions (sim only): a mark and a write to the same nonzero index in the same cycle; a write to an index ≥ SIZE.

Test Plan:
- Reset, then check idx 5 and read idx 5 -> o_check_rdy=1; next cycle o_read_vld=1, o_read_rdy=1, all outputs 0 during reset.
- Mark idx 7 at T, check idx 7 at T+1 -> 0; write idx 7 data 0xDEAD at T+3 with check and read of idx 7 at T+3 -> o_check_rdy=1 at T+3; o_read_data=0xDEAD, o_read_rdy=1 at T+4.
- Ports 1 and 4 both write idx 12 (0x11, 0x44) at T, read idx 12 at T -> T+1 o_read_data=0x44, o_write_conflict=1; read at T+1 returns 0x44 from storage.
- Mark idx 20 and write idx 20 at T -> at T+1 check idx 20 = 0 and storage holds the written data.
- Mark idx 30 and 31, then i_flush with a same-cycle mark of idx 33 -> next cycle checks of 30, 31, 33 all return 1.
- HAS_ZERO=1: write 0xFF to idx 0, read idx 0 -> o_read_data=0, o_read_rdy=1; read idx 80 with SIZE=80 -> data 0, rdy 0.
